mac_tile: RTL and testbench
===========================

MAC_TILE -- requirements
Module: mac_tile

Interface
REQ-001 Parameter a_bw, default 2, width of each activation lane.
REQ-002 Parameter w_bw, default 4, width of each weight lane (two's complement).
REQ-003 Parameter psum_bw, default 16, width of partial sums (two's complement).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ctrl  input  1  mode select: 0 = dual 2-bit lanes, 1 = single 4-bit activation.
REQ-007 inst_w  input  2  instruction: bit0 = load weight, bit1 = execute.
REQ-008 in_x_0, in_x_1  input  a_bw  activations from the west, unsigned.
REQ-009 in_w_0, in_w_1  input  w_bw  weights from the west.
REQ-010 in_psum_c_0, in_psum_c_1  input  psum_bw  incoming partial sums.
REQ-011 out_s_0, out_s_1  output  psum_bw  registered partial-sum results.
REQ-012 out_x_0, out_x_1  output  a_bw  registered activations forwarded east.
REQ-013 out_w_0, out_w_1  output  w_bw  registered weights forwarded east.
REQ-014 inst_e  output  2  inst_w delayed by one cycle, forwarded east.

Function
REQ-015 With inst_w[0]=1 and ctrl=0, the weight registers SHALL capture w_reg0<=in_w_0 and w_reg1<=in_w_1.
REQ-016 With inst_w[0]=1 and ctrl=1, in_w_0 SHALL be broadcast into both weight registers; in_w_1 is ignored.
REQ-017 With inst_w[0]=1, out_w_0/out_w_1 SHALL register the values just loaded; otherwise they hold.
REQ-018 With inst_w[1]=1 and ctrl=0, the tile SHALL compute out_s_i <= in_psum_c_i + zext(in_x_i) * sext(w_reg_i) for i=0,1.
REQ-019 With inst_w[1]=1 and ctrl=1, the tile SHALL compute out_s_0 <= in_psum_c_0 + zext({in_x_1,in_x_0}) * sext(w_reg0), and out_s_1 <= in_psum_c_1.
REQ-020 Products SHALL be sign-extended to psum_bw; by default the add wraps modulo 2^psum_bw.
REQ-021 With inst_w[1]=1, out_x_i SHALL register in_x_i; otherwise out_x and out_s hold.
REQ-022 Result latency SHALL be exactly one clock after the execute cycle.
REQ-023 inst_e SHALL equal the previous cycle's inst_w every cycle.
REQ-024 If inst_w=11, execute SHALL use the weights held before this edge, and the load takes effect on the same edge.
REQ-025 A ctrl change SHALL take effect in the same cycle it is applied; stored weights are not altered by the change.

Reset
REQ-026 While reset=1 at a clock edge, all weight registers, out_s_*, out_x_*, out_w_* and inst_e SHALL become 0.
REQ-027 Reset SHALL override any simultaneous load or execute, including a reset mid-operation.

Configuration
REQ-028 When macro MAC_TILE_SAT_EN is defined, each psum add SHALL saturate to the signed psum_bw range.
REQ-029 When MAC_TILE_SAT_EN is not defined, each psum add SHALL wrap modulo 2^psum_bw.

Structure
REQ-030 Package mac_tile_pkg SHALL hold the default widths and the constants for the inst bit indices (INST_LOAD=0, INST_EXEC=1).
REQ-031 One sub-module, mac_lane, SHALL implement the multiply-add, with an activation width of 2*a_bw; mac_tile SHALL instantiate it twice.
REQ-032 In 2-bit mode, each mac_lane activation input SHALL be zero-extended.

Verification
REQ-033 Reset: reset=1 for 2 cycles -> all outputs are 0.
REQ-034 ctrl=0, load w0=2/w1=3, then execute x0=1, x1=2, psum 5/10 -> out_s_0=7, out_s_1=16 one cycle later, and inst_e=10.
REQ-035 ctrl=1, load in_w_0=5, then execute x1=1, x0=2 (6), psum 0/0 -> out_s_0=30, out_s_1=0.
REQ-036 ctrl=1, w=5, execute x1=3, x0=3 (15), psum0=10 -> out_s_0=85.
REQ-037 ctrl=0, w0=4'b1111 (-1), execute x0=3, psum0=0 -> out_s_0=16'hFFFD.
REQ-038 psum0=16'h7FFF, w0=1, x0=1 -> out_s_0=16'h7FFF with MAC_TILE_SAT_EN defined, and 16'h8000 without it.

Source files
------------

// File: rtl/mac_tile_pkg.sv
// Shared widths and instruction bit positions for the mac_tile block.
package mac_tile_pkg;
  localparam int A_BW      = 2;
  localparam int W_BW      = 4;
  localparam int PSUM_BW   = 16;
  localparam int INST_LOAD = 0;
  localparam int INST_EXEC = 1;
endpackage

// File: rtl/mac_tile_mac_lane.sv
// One multiply-add lane: psum + zext(act) * sext(w).
// Saturating add when MAC_TILE_SAT_EN is defined, otherwise wraps.
module mac_lane
  import mac_tile_pkg::*;
#(
  parameter int act_bw  = 2 * A_BW,
  parameter int w_bw    = W_BW,
  parameter int psum_bw = PSUM_BW
) (
  input  logic [act_bw-1:0]  i_act,
  input  logic [w_bw-1:0]    i_w,
  input  logic [psum_bw-1:0] i_psum,
  output logic [psum_bw-1:0] o_sum
);
  localparam int PW = act_bw + w_bw + 1;

  logic signed [PW-1:0]    w_prod;
  logic [psum_bw-1:0]      w_prod_ext;

  assign w_prod = $signed({1'b0, i_act}) * $signed(i_w);
  assign w_prod_ext = {{(psum_bw-PW){w_prod[PW-1]}}, w_prod};

`ifdef MAC_TILE_SAT_EN
  logic [psum_bw:0] w_wide;
  logic [psum_bw-1:0] w_max;
  logic [psum_bw-1:0] w_min;

  assign w_wide = {i_psum[psum_bw-1], i_psum}
                + {w_prod_ext[psum_bw-1], w_prod_ext};
  assign w_max = {1'b0, {(psum_bw-1){1'b1}}};
  assign w_min = {1'b1, {(psum_bw-1){1'b0}}};

  // Top two bits disagree only on signed overflow.
  always_comb begin
    o_sum = w_wide[psum_bw-1:0];
    if (w_wide[psum_bw] != w_wide[psum_bw-1])
      o_sum = w_wide[psum_bw] ? w_min : w_max;
  end
`else
  assign o_sum = i_psum + w_prod_ext;
`endif
endmodule

// File: rtl/mac_tile.sv
// Dual-lane weight-stationary MAC tile with a fused 4-bit activation mode.
// Optional saturating accumulate via MAC_TILE_SAT_EN.
module mac_tile
  import mac_tile_pkg::*;
#(
  parameter int a_bw    = A_BW,
  parameter int w_bw    = W_BW,
  parameter int psum_bw = PSUM_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ctrl,
  input  logic [1:0]         inst_w,
  input  logic [a_bw-1:0]    in_x_0,
  input  logic [a_bw-1:0]    in_x_1,
  input  logic [w_bw-1:0]    in_w_0,
  input  logic [w_bw-1:0]    in_w_1,
  input  logic [psum_bw-1:0] in_psum_c_0,
  input  logic [psum_bw-1:0] in_psum_c_1,
  output logic [psum_bw-1:0] out_s_0,
  output logic [psum_bw-1:0] out_s_1,
  output logic [a_bw-1:0]    out_x_0,
  output logic [a_bw-1:0]    out_x_1,
  output logic [w_bw-1:0]    out_w_0,
  output logic [w_bw-1:0]    out_w_1,
  output logic [1:0]         inst_e
);
  logic [w_bw-1:0]    r_w0;
  logic [w_bw-1:0]    r_w1;
  logic [2*a_bw-1:0]  w_act0;
  logic [2*a_bw-1:0]  w_act1;
  logic [w_bw-1:0]    w_ld1;
  logic [psum_bw-1:0] w_sum0;
  logic [psum_bw-1:0] w_sum1;

  // Fused mode feeds lane 0 the concatenated activation pair.
  assign w_act0 = ctrl ? {in_x_1, in_x_0} : {{a_bw{1'b0}}, in_x_0};
  assign w_act1 = {{a_bw{1'b0}}, in_x_1};
  assign w_ld1  = ctrl ? in_w_0 : in_w_1;

  mac_lane #(
    .act_bw(2*a_bw), .w_bw(w_bw), .psum_bw(psum_bw)
  ) u_lane0 (
    .i_act(w_act0), .i_w(r_w0), .i_psum(in_psum_c_0), .o_sum(w_sum0)
  );

  mac_lane #(
    .act_bw(2*a_bw), .w_bw(w_bw), .psum_bw(psum_bw)
  ) u_lane1 (
    .i_act(w_act1), .i_w(r_w1), .i_psum(in_psum_c_1), .o_sum(w_sum1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w0    <= '0;
      r_w1    <= '0;
      out_s_0 <= '0;
      out_s_1 <= '0;
      out_x_0 <= '0;
      out_x_1 <= '0;
      out_w_0 <= '0;
      out_w_1 <= '0;
      inst_e  <= '0;
    end else begin
      if (inst_w[INST_LOAD]) begin
        r_w0    <= in_w_0;
        r_w1    <= w_ld1;
        out_w_0 <= in_w_0;
        out_w_1 <= w_ld1;
      end
      if (inst_w[INST_EXEC]) begin
        out_s_0 <= w_sum0;
        out_s_1 <= ctrl ? in_psum_c_1 : w_sum1;
        out_x_0 <= in_x_0;
        out_x_1 <= in_x_1;
      end
      inst_e <= inst_w;
    end
  end
endmodule

// File: tb/tb_mac_tile.sv
// Scoreboard bench for mac_tile: directed vectors, monitor pops on inst_e exec.
module tb_mac_tile;
  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl;
  logic [1:0]  inst_w;
  logic [1:0]  in_x_0, in_x_1;
  logic [3:0]  in_w_0, in_w_1;
  logic [15:0] in_psum_c_0, in_psum_c_1;
  logic [15:0] out_s_0, out_s_1;
  logic [1:0]  out_x_0, out_x_1;
  logic [3:0]  out_w_0, out_w_1;
  logic [1:0]  inst_e;

  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    logic [1:0]  x0;
    logic [1:0]  x1;
    logic [1:0]  ie;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mac_tile dut (
    .clk(clk), .reset(reset), .ctrl(ctrl), .inst_w(inst_w),
    .in_x_0(in_x_0), .in_x_1(in_x_1),
    .in_w_0(in_w_0), .in_w_1(in_w_1),
    .in_psum_c_0(in_psum_c_0), .in_psum_c_1(in_psum_c_1),
    .out_s_0(out_s_0), .out_s_1(out_s_1),
    .out_x_0(out_x_0), .out_x_1(out_x_1),
    .out_w_0(out_w_0), .out_w_1(out_w_1),
    .inst_e(inst_e)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every presented execute result is matched to the queue head.
  always @(negedge clk) begin
    if (inst_e[1] === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got s0=%h with empty queue",
                 out_s_0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_s_0", out_s_0, e.s0);
        chk("out_s_1", out_s_1, e.s1);
        chk("out_x_0", 16'(out_x_0), 16'(e.x0));
        chk("out_x_1", 16'(out_x_1), 16'(e.x1));
        chk("inst_e", 16'(inst_e), 16'(e.ie));
      end
    end
  end

  task automatic cyc(input logic rst, input logic c, input logic [1:0] ins,
                     input logic [1:0] x0, input logic [1:0] x1,
                     input logic [3:0] w0, input logic [3:0] w1,
                     input logic [15:0] p0, input logic [15:0] p1);
    reset = rst; ctrl = c; inst_w = ins;
    in_x_0 = x0; in_x_1 = x1; in_w_0 = w0; in_w_1 = w1;
    in_psum_c_0 = p0; in_psum_c_1 = p1;
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic c, input logic [1:0] ins,
                    input logic [1:0] x0, input logic [1:0] x1,
                    input logic [3:0] w0, input logic [3:0] w1,
                    input logic [15:0] p0, input logic [15:0] p1,
                    input logic [15:0] s0, input logic [15:0] s1);
    exp_t e;
    e.s0 = s0; e.s1 = s1; e.x0 = x0; e.x1 = x1; e.ie = ins;
    q.push_back(e);
    cyc(1'b0, c, ins, x0, x1, w0, w1, p0, p1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s0"}, out_s_0, 16'h0);
    chk({tag, "_s1"}, out_s_1, 16'h0);
    chk({tag, "_x"}, 16'({out_x_1, out_x_0}), 16'h0);
    chk({tag, "_w"}, 16'({out_w_1, out_w_0}), 16'h0);
    chk({tag, "_ie"}, 16'(inst_e), 16'h0);
  endtask

  initial begin
    logic [15:0] sat_exp;
`ifdef MAC_TILE_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h8000;
`endif
    cyc(1'b1, 1'b0, 2'b00, 2'd3, 2'd3, 4'hF, 4'hF, 16'h1234, 16'h1);
    cyc(1'b1, 1'b0, 2'b00, 2'd3, 2'd3, 4'hF, 4'hF, 16'h1234, 16'h1);
    chk_zero("reset");

    // dual lanes: load 2/3 then execute
    cyc(1'b0, 1'b0, 2'b01, 2'd0, 2'd0, 4'd2, 4'd3, 16'd0, 16'd0);
    chk("load_w0", 16'(out_w_0), 16'd2);
    chk("load_w1", 16'(out_w_1), 16'd3);
    chk("load_ie", 16'(inst_e), 16'b01);
    ex(1'b0, 2'b10, 2'd1, 2'd2, 4'd0, 4'd0, 16'd5, 16'd10, 16'd7, 16'd16);

    // idle: outputs hold
    cyc(1'b0, 1'b0, 2'b00, 2'd3, 2'd3, 4'd9, 4'd9, 16'd99, 16'd99);
    chk("hold_s0", out_s_0, 16'd7);
    chk("hold_w1", 16'(out_w_1), 16'd3);
    chk("idle_ie", 16'(inst_e), 16'b00);

    // fused mode: broadcast 5, in_w_1 ignored
    cyc(1'b0, 1'b1, 2'b01, 2'd0, 2'd0, 4'd5, 4'd9, 16'd0, 16'd0);
    chk("bcast_w0", 16'(out_w_0), 16'd5);
    chk("bcast_w1", 16'(out_w_1), 16'd5);
    ex(1'b1, 2'b10, 2'd2, 2'd1, 4'd0, 4'd0, 16'd0, 16'd0, 16'd30, 16'd0);
    ex(1'b1, 2'b10, 2'd3, 2'd3, 4'd0, 4'd0, 16'd10, 16'd77,
       16'd85, 16'd77);

    // back to dual lanes, weights 5/5 retained
    ex(1'b0, 2'b10, 2'd3, 2'd1, 4'd0, 4'd0, 16'd0, 16'd0, 16'd15, 16'd5);

    // negative weight
    cyc(1'b0, 1'b0, 2'b01, 2'd0, 2'd0, 4'hF, 4'd7, 16'd0, 16'd0);
    ex(1'b0, 2'b10, 2'd3, 2'd3, 4'd0, 4'd0, 16'd0, 16'd1,
       16'hFFFD, 16'd22);

    // load+execute: execute sees old weights -1/7
    ex(1'b0, 2'b11, 2'd1, 2'd1, 4'd1, 4'd2, 16'd0, 16'd0,
       16'hFFFF, 16'd7);
    chk("ldex_w0", 16'(out_w_0), 16'd1);
    chk("ldex_w1", 16'(out_w_1), 16'd2);

    // overflow boundary
    ex(1'b0, 2'b10, 2'd1, 2'd0, 4'd0, 4'd0, 16'h7FFF, 16'h8000,
       sat_exp, 16'h8000);

    // reset overrides a simultaneous load+execute
    cyc(1'b1, 1'b1, 2'b11, 2'd3, 2'd3, 4'd7, 4'd7, 16'd5, 16'd5);
    chk_zero("midrst");
    ex(1'b0, 2'b10, 2'd3, 2'd3, 4'd0, 4'd0, 16'd4, 16'd6, 16'd4, 16'd6);
    cyc(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, 16'd0, 16'd0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
